// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 request path: scheduler state encoding,
// MIG command codes and burst geometry helper.
package ddr2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_CMD  = 2'd2,
    GAP     = 2'd3
  } sched_state_t;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // One WDF word carries two DDR beats, so a burst of N takes N/2 words.
  function automatic int beats_per_burst(input int write_burst);
    return write_burst / 2;
  endfunction

endpackage

// File: rtl/ddr2_wdf_beat_ctr.sv
// Beat counter for one WDF burst: counts enabled cycles 0..BEATS-1 and
// flags the final beat. Wraps to 0 after the last beat.
module ddr2_wdf_beat_ctr #(
  parameter int BEATS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic last
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Advance on every enabled beat, wrapping after the last one.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == CW'(BEATS - 1)) ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = en && (cnt_q == CW'(BEATS - 1));

endmodule

// File: rtl/ddr2_req_sched.sv
// DDR2 request scheduler: arbitrates host write bursts and reads in front of
// the address generator, streams write data into the MIG WDF and pulses the
// write/read address enables.
// Optional build macro SCHED_PATTERN_EN: write data comes from an internal
// 32-bit pattern counter instead of wr_data_in, and upstream is never popped.
module ddr2_req_sched
  import ddr2_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int WRITE_BURST = 8,
  parameter int MAX_WR_RUN  = 4
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  input  logic                        phy_init_done,
  input  logic                        wr_req,
  input  logic [2*DATA_WIDTH-1:0]     wr_data_in,
  output logic                        wr_data_rd,
  input  logic                        rd_req,
  input  logic                        addr_confilct,
  input  logic                        af_afull,
  input  logic                        wdf_afull,
  output logic                        wr_addr_en,
  output logic                        rd_addr_en,
  output logic                        rd_en,
  output logic                        app_wdf_wren,
  output logic [2*DATA_WIDTH-1:0]     app_wdf_data,
  output logic [2*DATA_WIDTH/8-1:0]   app_wdf_mask_data,
  output logic                        busy
);

  localparam int WDF_W = 2 * DATA_WIDTH;
  localparam int BEATS = beats_per_burst(WRITE_BURST);
  localparam int RUN_W = $clog2(MAX_WR_RUN + 1);

  if (!(WRITE_BURST == 4 || WRITE_BURST == 8)) begin : g_bad_burst
    $error("ddr2_req_sched: WRITE_BURST must be 4 or 8");
  end

  sched_state_t     state_q, state_d;
  logic [RUN_W-1:0] wr_run_cnt_q, wr_run_cnt_d;
  logic             wr_data_rd_q, wr_data_rd_d;
  logic             wr_addr_en_q, wr_addr_en_d;
  logic             rd_addr_en_q, rd_addr_en_d;
  logic             app_wdf_wren_q, app_wdf_wren_d;
  logic [WDF_W-1:0] app_wdf_data_q, app_wdf_data_d;
  logic             in_wr;
  logic             last_beat;
  logic             wr_ok, rd_ok;

`ifdef SCHED_PATTERN_EN
  if (WDF_W % 32 != 0) begin : g_bad_pattern_width
    $error("ddr2_req_sched: 2*DATA_WIDTH must be a multiple of 32 for the pattern source");
  end

  logic [31:0] pat_cnt_q, pat_cnt_d;
  logic        unused_wr_data;
  assign unused_wr_data = ^wr_data_in;
`endif

  assign in_wr = (state_q == WR_DATA);

  ddr2_wdf_beat_ctr #(
    .BEATS (BEATS)
  ) u_beat_ctr (
    .clk  (sys_clk),
    .rst  (reset),
    .en   (in_wr),
    .last (last_beat)
  );

  // Arbitration, burst sequencing and next values of the registered strobes.
  always_comb begin
    wr_ok        = wr_req && !wdf_afull && !af_afull;
    rd_ok        = rd_req && !af_afull && !addr_confilct;
    state_d      = state_q;
    wr_run_cnt_d = wr_run_cnt_q;

    case (state_q)
      IDLE: begin
        if (phy_init_done) begin
          // A blocked read (conflict) leaves rd_ok low, so writes keep flowing.
          if (rd_ok && (wr_run_cnt_q == RUN_W'(MAX_WR_RUN) || !wr_ok)) begin
            state_d      = RD_CMD;
            wr_run_cnt_d = '0;
          end else if (wr_ok) begin
            state_d = WR_DATA;
            if (wr_run_cnt_q != RUN_W'(MAX_WR_RUN)) begin
              wr_run_cnt_d = wr_run_cnt_q + RUN_W'(1);
            end
          end
        end
      end
      WR_DATA: if (last_beat) state_d = GAP;
      RD_CMD:  state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The pop strobe is aligned with the WR_DATA cycles; the word visible on
    // the show-ahead port in each of those cycles is captured at its end, so
    // the WDF write and the address enable trail the pop by one cycle.
    rd_addr_en_d   = (state_d == RD_CMD);
    app_wdf_wren_d = in_wr;
    wr_addr_en_d   = in_wr && last_beat;

`ifdef SCHED_PATTERN_EN
    wr_data_rd_d   = 1'b0;
    pat_cnt_d      = in_wr ? pat_cnt_q + 32'd1 : pat_cnt_q;
    app_wdf_data_d = in_wr ? {(WDF_W/32){pat_cnt_q}} : app_wdf_data_q;
`else
    wr_data_rd_d   = (state_d == WR_DATA);
    app_wdf_data_d = in_wr ? wr_data_in : app_wdf_data_q;
`endif
  end

  // State, run counter and registered outputs; reset abandons any burst.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_run_cnt_q   <= '0;
      wr_data_rd_q   <= 1'b0;
      wr_addr_en_q   <= 1'b0;
      rd_addr_en_q   <= 1'b0;
      app_wdf_wren_q <= 1'b0;
      app_wdf_data_q <= '0;
`ifdef SCHED_PATTERN_EN
      pat_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      wr_run_cnt_q   <= wr_run_cnt_d;
      wr_data_rd_q   <= wr_data_rd_d;
      wr_addr_en_q   <= wr_addr_en_d;
      rd_addr_en_q   <= rd_addr_en_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      app_wdf_data_q <= app_wdf_data_d;
`ifdef SCHED_PATTERN_EN
      pat_cnt_q      <= pat_cnt_d;
`endif
    end
  end

  assign wr_data_rd        = wr_data_rd_q;
  assign wr_addr_en        = wr_addr_en_q;
  assign rd_addr_en        = rd_addr_en_q;
  assign app_wdf_wren      = app_wdf_wren_q;
  assign app_wdf_data      = app_wdf_data_q;
  assign app_wdf_mask_data = '0;
  assign rd_en             = rd_req;
  assign busy              = (state_q != IDLE);

endmodule

// File: doc/ddr2_req_sched.md
Name: ddr2_req_sched

Overview:
- Request scheduler that sits directly upstream of the DDR2 address generator.
- Arbitrates host write-burst and read requests.
- Per write: streams the burst's data words into the MIG write-data FIFO, then pulses the address generator's write-address enable.
- Per read: pulses the read-address enable only when the generator reports no read/write address conflict. Honours MIG FIFO almost-full flags and PHY init status.

Parameters:
- DATA_WIDTH, 64, DDR data width; one WDF word is 2*DATA_WIDTH bits.
- WRITE_BURST, 8, burst length (4 or 8); beats per write = WRITE_BURST/2.
- MAX_WR_RUN, 4, consecutive write grants allowed before a pending read is forced to win once.

Ports:
- sys_clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- phy_init_done  in  1  MIG calibration complete; no grants while low
- wr_req  in  1  upstream holds at least one full burst of write data (show-ahead)
- wr_data_in  in  2*DATA_WIDTH  current upstream write word
- wr_data_rd  out  1  pop strobe to upstream, one per beat
- rd_req  in  1  host read request, level
- addr_confilct  in  1  from address generator, combinational
- af_afull  in  1  MIG address FIFO almost full
- wdf_afull  in  1  MIG write-data FIFO almost full
- wr_addr_en  out  1  one-cycle pulse per write burst
- rd_addr_en  out  1  one-cycle pulse per read burst
- rd_en  out  1  read-pending indication to the address generator
- app_wdf_wren  out  1  WDF write strobe
- app_wdf_data  out  2*DATA_WIDTH  WDF data
- app_wdf_mask_data  out  2*DATA_WIDTH/8  byte mask, always 0
- busy  out  1  state != IDLE

Behaviour:
- Single clock; reset is synchronous, active-high, sampled on posedge sys_clk. All outputs are registered except rd_en and busy.
- Reset values: all strobes 0, app_wdf_data 0, mask 0, state IDLE, beat_cnt 0, wr_run_cnt 0.
- Reset mid-burst returns to IDLE immediately. Remaining beats are abandoned; words already popped are lost by design.
- rd_en = rd_req (combinational) so the generator's conflict check sees pending reads.
- States: IDLE, WR_DATA, RD_CMD, GAP.
- IDLE arbitration (only when phy_init_done=1):
  - wr_ok = wr_req & !wdf_afull & !af_afull.
  - rd_ok = rd_req & !af_afull & !addr_confilct.
  - If rd_ok and (wr_run_cnt == MAX_WR_RUN or !wr_ok): go to RD_CMD, clear wr_run_cnt.
  - Else if wr_ok: go to WR_DATA, increment wr_run_cnt (saturating at MAX_WR_RUN).
  - Else stay in IDLE.
- WR_DATA:
  - One beat per cycle for WRITE_BURST/2 cycles, unconditionally; almost-full margin covers it.
  - Each beat: app_wdf_wren=1, app_wdf_data=wr_data_in registered, wr_data_rd=1.
  - beat_cnt counts 0..WRITE_BURST/2-1.
  - On the last-beat cycle, wr_addr_en=1 for exactly that cycle; next state is GAP.
  - Latency: wr_addr_en rises WRITE_BURST/2 cycles after leaving IDLE, so the address reaches the address FIFO after all data.
- RD_CMD: rd_addr_en=1 for one cycle, then GAP.
- GAP: one idle cycle so generator addresses and the FIFO flags settle, then IDLE. Minimum spacing between grants is therefore 2 cycles for reads and WRITE_BURST/2+1 cycles for writes.
- Simultaneous wr_req and rd_req: write wins unless wr_run_cnt has saturated. A read blocked by addr_confilct never starves writes.
- phy_init_done dropping mid-burst: the burst completes, then no new grants.
- WRITE_BURST values other than 4 or 8 are illegal; an elaboration check flags them.

Optional Feature:
- Macro SCHED_PATTERN_EN.
- Defined: an internal 32-bit pattern counter replaces wr_data_in. Each beat's app_wdf_data = the counter replicated across 2*DATA_WIDTH bits; the counter increments per beat, resets to 0, and wraps at 2^32. wr_data_in is ignored and wr_data_rd stays 0. wr_req is still required as the write trigger.
- Undefined: data comes from wr_data_in as described above.

Decomposition:
- Shared package ddr2_pkg holds:
  - state encoding enum (IDLE=0, WR_DATA=1, RD_CMD=2, GAP=3);
  - MIG command constants (CMD_WR=3'b000, CMD_RD=3'b001);
  - localparam function beats_per_burst(WRITE_BURST).
- One natural sub-module, ddr2_wdf_beat_ctr: beat counter and last-beat flag, reused by the future read-data capture stage.

Test Plan:
- Reset then phy_init_done=1, wr_req=1 held, WRITE_BURST=8 -> 4 consecutive app_wdf_wren beats, wr_addr_en on beat 4 only, GAP, repeat; rd_addr_en never asserts.
- wr_req=1 and rd_req=1 held, addr_confilct=0, MAX_WR_RUN=4 -> grant order W,W,W,W,R,W,W,W,W,R.
- rd_req=1, addr_confilct=1 -> rd_addr_en stays 0. Release addr_confilct -> rd_addr_en pulses 2 cycles later (IDLE sample, then RD_CMD).
- af_afull=1 with both requests -> no strobes for 20 cycles. Drop af_afull -> write grant in the next cycle.
- Reset asserted on beat 2 of 4 -> next cycle all outputs 0, state IDLE, no wr_addr_en for that burst.
- SCHED_PATTERN_EN defined, two write bursts -> app_wdf_data low 32 bits = 0,1,2,3,4,5,6,7 and wr_data_rd=0 throughout.
